// File: rtl/mc_controller_hs_if.sv
// Handshake/control bundle between the instruction register, memory port and the
// multi-cycle datapath; the controller drives it through the master modport.
interface mc_controller_hs_if #(
    parameter int RET_W = 32
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             Zero;
    logic             mem_ack;
    logic             mem_req;
    logic             MemWrite;
    logic             AdrSrc;
    logic             IRWrite;
    logic             PCWrite;
    logic             RegWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ImmSrc;
    logic [3:0]       ALUControl;
    logic [RET_W-1:0] retired;
    logic             fault;
    logic [1:0]       fault_code;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ack,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
               retired, fault, fault_code
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ack,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
               retired, fault, fault_code
    );
endinterface

// File: rtl/mc_controller_hs.sv
// Multi-cycle RV32I control FSM with req/ack memory handshake, retired counter and
// sticky fault. Define MC_MEM_TIMEOUT_EN to bound memory waits to TIMEOUT_CYCLES.
module mc_controller_hs #(
    parameter int RET_W          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    mc_controller_hs_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_JAL, S_LUI, S_BRANCH, S_FAULT
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_e           state_q, state_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic [1:0]       fault_code_q, fault_code_d;

    logic             mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]       result_src, src_a, src_b;
    logic [2:0]       imm_src;
    alu_op_e          alu_ctl;

`ifdef MC_MEM_TIMEOUT_EN
    localparam int              CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    // funct3 011 (sltu) is outside this core's ALU and falls back to add.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic b5,
                                           input logic is_r);
        alu_op_e res;
        case (f3)
            3'b000:  res = (is_r && b5) ? ALU_SUB : ALU_ADD;
            3'b111:  res = ALU_AND;
            3'b110:  res = ALU_OR;
            3'b100:  res = ALU_XOR;
            3'b010:  res = ALU_SLT;
            3'b001:  res = ALU_SLL;
            3'b101:  res = b5 ? ALU_SRA : ALU_SRL;
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        retired_d    = retired_q;
        fault_code_d = fault_code_q;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        result_src   = 2'b00;
        src_a        = 2'b00;
        src_b        = 2'b00;
        imm_src      = 3'b000;
        alu_ctl      = ALU_ADD;

        unique case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                src_b      = 2'b10;
                result_src = 2'b10;
                if (bus.mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a   = 2'b01;
                src_b   = 2'b01;
                imm_src = 3'b010;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        state_d      = S_FAULT;
                        fault_code_d = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                imm_src = (bus.op == OP_STORE) ? 3'b001 : 3'b000;
                state_d = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ack) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (bus.mem_ack) state_d = S_FETCH;
            end
            S_EXECR: begin
                src_a   = 2'b10;
                alu_ctl = alu_decode(bus.funct3, bus.funct7b5, 1'b1);
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_ctl = alu_decode(bus.funct3, bus.funct7b5, 1'b0);
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                src_a    = 2'b01;
                src_b    = 2'b10;
                imm_src  = 3'b011;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_LUI: begin
                src_a   = 2'b11;
                src_b   = 2'b01;
                imm_src = 3'b100;
                state_d = S_ALUWB;
            end
            S_BRANCH: begin
                src_a   = 2'b10;
                alu_ctl = ALU_SUB;
                // Unsupported branch conditions simply fall through as not-taken.
                case (bus.funct3)
                    3'b000:  pc_write = bus.Zero;
                    3'b001:  pc_write = !bus.Zero;
                    default: pc_write = 1'b0;
                endcase
                state_d = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase

`ifdef MC_MEM_TIMEOUT_EN
        // Any cycle without an outstanding wait clears the counter, so it starts at 0 on
        // entry to every memory state.
        wait_cnt_d = '0;
        if (mem_req && !bus.mem_ack) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            if (wait_cnt_d == TIMEOUT_VAL) begin
                state_d      = S_FAULT;
                fault_code_d = 2'b10;
            end
        end
`endif

        if (state_d == S_FETCH &&
            (state_q == S_MEMWB || state_q == S_MEMWRITE ||
             state_q == S_ALUWB || state_q == S_BRANCH))
            retired_d = retired_q + RET_W'(1);
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            retired_q    <= '0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            retired_q    <= retired_d;
            fault_code_q <= fault_code_d;
        end
    end

`ifdef MC_MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end
`endif

    assign bus.mem_req    = mem_req;
    assign bus.MemWrite   = mem_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.IRWrite    = ir_write;
    assign bus.PCWrite    = pc_write;
    assign bus.RegWrite   = reg_write;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = alu_ctl;
    assign bus.retired    = retired_q;
    assign bus.fault      = (fault_code_q != 2'b00);
    assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_mc_controller_hs.sv
// Directed bench for mc_controller_hs: walks each instruction class through the FSM,
// checking the control word every cycle plus retired/fault state at boundaries.
module tb_mc_controller_hs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    mc_controller_hs_if #(.RET_W(32)) bus ();

    mc_controller_hs #(.RET_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Control word layout: req mw adr ir pcw rw | rs[1:0] sa[1:0] sb[1:0] imm[2:0] alu[3:0]
    function automatic logic [18:0] w(input logic req, input logic mw, input logic adr,
                                      input logic ir, input logic pcw, input logic rw,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [2:0] imm,
                                      input logic [3:0] alu);
        return {req, mw, adr, ir, pcw, rw, rs, sa, sb, imm, alu};
    endfunction

    function automatic logic [18:0] obs_word();
        return {bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite,
                bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                bus.ALUControl};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive mem_ack, compare the masked control word, then advance one cycle.
    task automatic step(input string tag, input logic ack, input logic [18:0] exp,
                        input logic [18:0] mask);
        bus.mem_ack = ack;
        #1;
        check(tag, 32'(obs_word() & mask), 32'(exp & mask));
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                             input logic zero);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = b5;
        bus.Zero     = zero;
    endtask

    logic [18:0] F_WAIT, F_ACK, DEC, ALUWB, MEMWB, MEMRD, MEMWR, MA_LW, MA_SW, JAL, LUI;
    logic [18:0] mFETCH, mDEC, mEXR, mEXI, mMEM, mWB, mJAL, mBR, mSTR;

    function automatic logic [18:0] execr(input logic [3:0] alu);
        return w(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, alu);
    endfunction

    function automatic logic [18:0] execi(input logic [3:0] alu);
        return w(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, alu);
    endfunction

    function automatic logic [18:0] branch(input logic pcw);
        return w(0, 0, 0, 0, pcw, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0001);
    endfunction

    initial begin
        F_WAIT = w(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000);
        F_ACK  = w(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000);
        DEC    = w(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 4'b0000);
        ALUWB  = w(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000);
        MEMWB  = w(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 4'b0000);
        MEMRD  = w(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000);
        MEMWR  = w(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000);
        MA_LW  = w(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000);
        MA_SW  = w(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000);
        JAL    = w(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 3'b011, 4'b0000);
        LUI    = w(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b100, 4'b0000);

        mFETCH = w(1, 1, 1, 1, 1, 1, 2'd3, 2'd3, 2'd3, 3'd0, 4'hf);
        mDEC   = w(1, 1, 0, 1, 1, 1, 2'd0, 2'd3, 2'd3, 3'd7, 4'h0);
        mEXR   = w(1, 1, 0, 1, 1, 1, 2'd0, 2'd3, 2'd3, 3'd0, 4'hf);
        mEXI   = w(1, 1, 0, 1, 1, 1, 2'd0, 2'd3, 2'd3, 3'd7, 4'hf);
        mMEM   = w(1, 1, 1, 1, 1, 1, 2'd0, 2'd0, 2'd0, 3'd0, 4'h0);
        mWB    = w(1, 1, 0, 1, 1, 1, 2'd3, 2'd0, 2'd0, 3'd0, 4'h0);
        mJAL   = w(1, 1, 0, 1, 1, 1, 2'd3, 2'd3, 2'd3, 3'd7, 4'hf);
        mBR    = w(1, 1, 0, 1, 1, 1, 2'd3, 2'd3, 2'd3, 3'd0, 4'hf);
        mSTR   = w(1, 1, 0, 1, 1, 1, 2'd0, 2'd0, 2'd0, 3'd0, 4'h0);

        bus.mem_ack = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_retired", bus.retired, 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_fault_code", 32'(bus.fault_code), 32'd0);
        rst = 1'b0;

        // add x3,x1,x2 with fetch ack after 3 wait cycles
        repeat (3) step("add_fetch_wait", 1'b0, F_WAIT, mFETCH);
        step("add_fetch_ack", 1'b1, F_ACK, mFETCH);
        step("add_decode", 1'b0, DEC, mDEC);
        step("add_execr", 1'b0, execr(4'b0000), mEXR);
        step("add_aluwb", 1'b0, ALUWB, mWB);
        check("add_retired", bus.retired, 32'd1);

        set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        step("sub_fetch", 1'b1, F_ACK, mFETCH);
        step("sub_decode", 1'b0, DEC, mDEC);
        step("sub_execr", 1'b0, execr(4'b0001), mEXR);
        step("sub_aluwb", 1'b0, ALUWB, mWB);

        set_instr(7'b0010011, 3'b101, 1'b1, 1'b0);
        step("srai_fetch", 1'b1, F_ACK, mFETCH);
        step("srai_decode", 1'b0, DEC, mDEC);
        step("srai_execi", 1'b0, execi(4'b1000), mEXI);
        step("srai_aluwb", 1'b0, ALUWB, mWB);

        // addi with instr[30] set must still add
        set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        step("addi_fetch", 1'b1, F_ACK, mFETCH);
        step("addi_decode", 1'b0, DEC, mDEC);
        step("addi_execi", 1'b0, execi(4'b0000), mEXI);
        step("addi_aluwb", 1'b0, ALUWB, mWB);

        set_instr(7'b0110011, 3'b010, 1'b0, 1'b0);
        step("slt_fetch", 1'b1, F_ACK, mFETCH);
        step("slt_decode", 1'b0, DEC, mDEC);
        step("slt_execr", 1'b0, execr(4'b0101), mEXR);
        step("slt_aluwb", 1'b0, ALUWB, mWB);
        check("alu_retired", bus.retired, 32'd5);

        // sw with ack delayed 5 cycles
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        step("sw_fetch", 1'b1, F_ACK, mFETCH);
        step("sw_decode", 1'b0, DEC, mDEC);
        step("sw_memadr", 1'b0, MA_SW, mEXI);
        repeat (5) step("sw_memwrite_wait", 1'b0, MEMWR, mMEM);
        step("sw_memwrite_ack", 1'b1, MEMWR, mMEM);
        check("sw_retired", bus.retired, 32'd6);

        // lw; ack during DECODE is ignored
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        step("lw_fetch", 1'b1, F_ACK, mFETCH);
        step("lw_decode_ack_ignored", 1'b1, DEC, mDEC);
        step("lw_memadr", 1'b0, MA_LW, mEXI);
        repeat (2) step("lw_memread_wait", 1'b0, MEMRD, mMEM);
        step("lw_memread_ack", 1'b1, MEMRD, mMEM);
        step("lw_memwb", 1'b0, MEMWB, mWB);
        check("lw_retired", bus.retired, 32'd7);

        set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        step("beq_fetch", 1'b1, F_ACK, mFETCH);
        step("beq_decode", 1'b0, DEC, mDEC);
        step("beq_taken", 1'b0, branch(1'b1), mBR);

        set_instr(7'b1100011, 3'b001, 1'b0, 1'b1);
        step("bne_fetch", 1'b1, F_ACK, mFETCH);
        step("bne_decode", 1'b0, DEC, mDEC);
        step("bne_not_taken", 1'b0, branch(1'b0), mBR);

        set_instr(7'b1100011, 3'b100, 1'b0, 1'b1);
        step("blt_fetch", 1'b1, F_ACK, mFETCH);
        step("blt_decode", 1'b0, DEC, mDEC);
        step("blt_not_taken", 1'b0, branch(1'b0), mBR);
        check("branch_retired", bus.retired, 32'd10);
        check("branch_no_fault", 32'(bus.fault), 32'd0);

        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        step("jal_fetch", 1'b1, F_ACK, mFETCH);
        step("jal_decode", 1'b0, DEC, mDEC);
        step("jal_exec", 1'b0, JAL, mJAL);
        step("jal_aluwb", 1'b0, ALUWB, mWB);

        set_instr(7'b0110111, 3'b000, 1'b0, 1'b0);
        step("lui_fetch", 1'b1, F_ACK, mFETCH);
        step("lui_decode", 1'b0, DEC, mDEC);
        step("lui_exec", 1'b0, LUI, mEXI);
        step("lui_aluwb", 1'b0, ALUWB, mWB);
        check("lui_retired", bus.retired, 32'd12);

        // reset in the middle of a store wait abandons it
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        step("abort_fetch", 1'b1, F_ACK, mFETCH);
        step("abort_decode", 1'b0, DEC, mDEC);
        step("abort_memadr", 1'b0, MA_SW, mEXI);
        repeat (2) step("abort_memwrite_wait", 1'b0, MEMWR, mMEM);
        #1 rst = 1'b1;
        #1;
        check("abort_rst_retired", bus.retired, 32'd0);
        check("abort_rst_fault", 32'(bus.fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
        step("abort_refetch", 1'b0, F_WAIT, mFETCH);
        step("post_abort_fetch", 1'b1, F_ACK, mFETCH);
        step("post_abort_decode", 1'b0, DEC, mDEC);
        step("post_abort_execr", 1'b0, execr(4'b0000), mEXR);
        step("post_abort_aluwb", 1'b0, ALUWB, mWB);
        check("post_abort_retired", bus.retired, 32'd1);

        // illegal opcode -> terminal fault
        set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        step("ill_fetch", 1'b1, F_ACK, mFETCH);
        check("ill_pre_fault", 32'(bus.fault), 32'd0);
        step("ill_decode", 1'b0, DEC, mDEC);
        for (int i = 0; i < 4; i++) step("fault_strobes", i[0], 19'd0, mSTR);
        check("fault_flag", 32'(bus.fault), 32'd1);
        check("fault_code_illegal", 32'(bus.fault_code), 32'd1);
        check("fault_retired_frozen", bus.retired, 32'd1);

        #1 rst = 1'b1;
        #1;
        check("fault_rst_retired", bus.retired, 32'd0);
        check("fault_rst_flag", 32'(bus.fault), 32'd0);
        check("fault_rst_code", 32'(bus.fault_code), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("fault_rst_fetch", 1'b0, F_WAIT, mFETCH);

        // long load wait: bounded with the timeout feature, unbounded without
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        step("to_fetch", 1'b1, F_ACK, mFETCH);
        step("to_decode", 1'b0, DEC, mDEC);
        step("to_memadr", 1'b0, MA_LW, mEXI);
`ifdef MC_MEM_TIMEOUT_EN
        repeat (16) step("to_memread_wait", 1'b0, MEMRD, mMEM);
        step("to_fault_strobes", 1'b0, 19'd0, mSTR);
        check("to_fault_flag", 32'(bus.fault), 32'd1);
        check("to_fault_code", 32'(bus.fault_code), 32'd2);
        check("to_retired", bus.retired, 32'd0);
`else
        repeat (20) step("to_memread_wait", 1'b0, MEMRD, mMEM);
        step("to_memread_ack", 1'b1, MEMRD, mMEM);
        step("to_memwb", 1'b0, MEMWB, mWB);
        check("to_retired", bus.retired, 32'd1);
        check("to_no_fault", 32'(bus.fault), 32'd0);
        check("to_code_none", 32'(bus.fault_code), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
